// File: rtl/decode_stage.sv
// RV32I decode stage: DEPTH-entry instruction queue feeding a registered decoded bundle.
// Define DECODE_MEXT_EN to accept M-extension (funct7=0000001) R-type ops as legal.
module decode_stage #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [6:0]            opcode,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [2:0]            funct3,
    output logic [6:0]            funct7,
    output logic [XLEN-1:0]       imm,
    output logic                  is_alu_op,
    output logic                  is_load,
    output logic                  is_store,
    output logic                  is_branch,
    output logic                  is_jump,
    output logic                  is_lui,
    output logic                  is_auipc,
    output logic                  is_muldiv,
    output logic                  illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [6:0]            opcode;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic [XLEN-1:0]       imm;
        logic                  is_alu_op;
        logic                  is_load;
        logic                  is_store;
        logic                  is_branch;
        logic                  is_jump;
        logic                  is_lui;
        logic                  is_auipc;
        logic                  is_muldiv;
        logic                  illegal;
    } bundle_t;

    logic [31:0]      instr_mem_q [DEPTH];
    logic [XLEN-1:0]  pc_mem_q    [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    bundle_t          bundle_q, bundle_d;
    bundle_t          dec;
    logic             push, pop;

    logic [31:0]        head;
    logic [4:0]         rd_f, rs1_f, rs2_f;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic               use_rd, use_rs1, use_rs2, bad;
    logic signed [31:0] imm32;

    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count_q != '0) && (!out_valid_q || out_ready);

    // Combinational decode of the queue head; consumed only when it is popped.
    always_comb begin
        head    = instr_mem_q[rd_ptr_q];
        rd_f    = head[11:7];
        rs1_f   = head[19:15];
        rs2_f   = head[24:20];
        f3      = head[14:12];
        f7      = head[31:25];
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        bad     = 1'b0;
        imm32   = '0;
        dec     = '0;

        case (head[6:0])
            OP_R: begin
                {use_rd, use_rs1, use_rs2} = 3'b111;
                dec.is_alu_op = 1'b1;
                if (f7 == 7'b0000000) begin
                    bad = 1'b0;
                end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
                    bad = 1'b0;
`ifdef DECODE_MEXT_EN
                end else if (f7 == 7'b0000001) begin
                    dec.is_muldiv = 1'b1;
`endif
                end else begin
                    bad = 1'b1;
                end
            end
            OP_IMM: begin
                {use_rd, use_rs1} = 2'b11;
                dec.is_alu_op = 1'b1;
                imm32 = {{20{head[31]}}, head[31:20]};
                if (f3 == 3'b001 && f7 != 7'b0000000)
                    bad = 1'b1;
                if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
                    bad = 1'b1;
            end
            OP_LOAD: begin
                {use_rd, use_rs1} = 2'b11;
                dec.is_load = 1'b1;
                imm32 = {{20{head[31]}}, head[31:20]};
                bad   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_STORE: begin
                {use_rs1, use_rs2} = 2'b11;
                dec.is_store = 1'b1;
                imm32 = {{20{head[31]}}, head[31:25], head[11:7]};
                bad   = (f3 > 3'b010);
            end
            OP_BRANCH: begin
                {use_rs1, use_rs2} = 2'b11;
                dec.is_branch = 1'b1;
                imm32 = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
                bad   = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_LUI: begin
                use_rd     = 1'b1;
                dec.is_lui = 1'b1;
                imm32      = {head[31:12], 12'b0};
            end
            OP_AUIPC: begin
                use_rd       = 1'b1;
                dec.is_auipc = 1'b1;
                imm32        = {head[31:12], 12'b0};
            end
            OP_JAL: begin
                use_rd      = 1'b1;
                dec.is_jump = 1'b1;
                imm32 = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
            end
            OP_JALR: begin
                {use_rd, use_rs1} = 2'b11;
                dec.is_jump = 1'b1;
                imm32 = {{20{head[31]}}, head[31:20]};
                bad   = (f3 != 3'b000);
            end
            default: bad = 1'b1;
        endcase

        // Register fields beyond the architectural file (RV32E) make the op illegal.
        if ((use_rd  && ((rd_f  >> REG_ADDR_W) != 5'd0)) ||
            (use_rs1 && ((rs1_f >> REG_ADDR_W) != 5'd0)) ||
            (use_rs2 && ((rs2_f >> REG_ADDR_W) != 5'd0)))
            bad = 1'b1;

        dec.pc     = pc_mem_q[rd_ptr_q];
        dec.opcode = head[6:0];
        dec.rd     = rd_f[REG_ADDR_W-1:0];
        dec.rs1    = rs1_f[REG_ADDR_W-1:0];
        dec.rs2    = rs2_f[REG_ADDR_W-1:0];
        dec.funct3 = f3;
        dec.funct7 = f7;
        dec.imm    = XLEN'(imm32);

        if (bad) begin
            dec.is_alu_op = 1'b0;
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
            dec.is_branch = 1'b0;
            dec.is_jump   = 1'b0;
            dec.is_lui    = 1'b0;
            dec.is_auipc  = 1'b0;
            dec.is_muldiv = 1'b0;
            dec.imm       = '0;
            dec.illegal   = 1'b1;
        end
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;

        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (pop) begin
                out_valid_d = 1'b1;
                bundle_d    = dec;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    // Queue storage needs no reset: count_q alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            instr_mem_q[wr_ptr_q] <= in_instr;
            pc_mem_q[wr_ptr_q]    <= in_pc;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = bundle_q.pc;
    assign opcode    = bundle_q.opcode;
    assign rd        = bundle_q.rd;
    assign rs1_addr  = bundle_q.rs1;
    assign rs2_addr  = bundle_q.rs2;
    assign funct3    = bundle_q.funct3;
    assign funct7    = bundle_q.funct7;
    assign imm       = bundle_q.imm;
    assign is_alu_op = bundle_q.is_alu_op;
    assign is_load   = bundle_q.is_load;
    assign is_store  = bundle_q.is_store;
    assign is_branch = bundle_q.is_branch;
    assign is_jump   = bundle_q.is_jump;
    assign is_lui    = bundle_q.is_lui;
    assign is_auipc  = bundle_q.is_auipc;
    assign is_muldiv = bundle_q.is_muldiv;
    assign illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an RV32I and an RV32E instance share stimulus,
// each checked against a behavioural decode model; honours DECODE_MEXT_EN.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        i_in_ready, i_out_valid;
    logic [31:0] i_out_pc, i_imm;
    logic [6:0]  i_opcode, i_funct7;
    logic [4:0]  i_rd, i_rs1, i_rs2;
    logic [2:0]  i_funct3;
    logic        i_alu, i_load, i_store, i_branch, i_jump, i_lui, i_auipc, i_muldiv, i_illegal;

    logic        e_in_ready, e_out_valid;
    logic [31:0] e_out_pc, e_imm;
    logic [6:0]  e_opcode, e_funct7;
    logic [3:0]  e_rd, e_rs1, e_rs2;
    logic [2:0]  e_funct3;
    logic        e_alu, e_load, e_store, e_branch, e_jump, e_lui, e_auipc, e_muldiv, e_illegal;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [7:0]  flags;   // alu, load, store, branch, jump, lui, auipc, muldiv
        logic        illegal;
    } bund_t;

    bund_t act_i, act_e;
    bund_t exp_i[$];
    bund_t exp_e[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    decode_stage dut_i (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(i_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(i_out_valid), .out_ready(out_ready), .out_pc(i_out_pc),
        .opcode(i_opcode), .rd(i_rd), .rs1_addr(i_rs1), .rs2_addr(i_rs2),
        .funct3(i_funct3), .funct7(i_funct7), .imm(i_imm),
        .is_alu_op(i_alu), .is_load(i_load), .is_store(i_store), .is_branch(i_branch),
        .is_jump(i_jump), .is_lui(i_lui), .is_auipc(i_auipc), .is_muldiv(i_muldiv),
        .illegal(i_illegal)
    );

    decode_stage #(.REG_ADDR_W(4)) dut_e (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(e_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(e_out_valid), .out_ready(out_ready), .out_pc(e_out_pc),
        .opcode(e_opcode), .rd(e_rd), .rs1_addr(e_rs1), .rs2_addr(e_rs2),
        .funct3(e_funct3), .funct7(e_funct7), .imm(e_imm),
        .is_alu_op(e_alu), .is_load(e_load), .is_store(e_store), .is_branch(e_branch),
        .is_jump(e_jump), .is_lui(e_lui), .is_auipc(e_auipc), .is_muldiv(e_muldiv),
        .illegal(e_illegal)
    );

    assign act_i = {i_out_pc, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm,
                    i_alu, i_load, i_store, i_branch, i_jump, i_lui, i_auipc, i_muldiv, i_illegal};
    assign act_e = {e_out_pc, e_opcode, 1'b0, e_rd, 1'b0, e_rs1, 1'b0, e_rs2, e_funct3, e_funct7,
                    e_imm, e_alu, e_load, e_store, e_branch, e_jump, e_lui, e_auipc, e_muldiv,
                    e_illegal};

    // Reference decode written straight from the ISA rules using signed integer arithmetic.
    function automatic bund_t ref_decode(input logic [31:0] w, input logic [31:0] pc, input bit rv32e);
        bund_t    b;
        bit       ok;
        bit [2:0] uses;
        int       s, im;
        int       f3, f7;
        s  = w;
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        b  = '0;
        ok = 1;
        im = 0;
        uses = 3'b000;
        case (w[6:0])
            7'h33: begin
                uses = 3'b111; b.flags[7] = 1;
                if (f7 == 1) begin
`ifdef DECODE_MEXT_EN
                    b.flags[0] = 1;
`else
                    ok = 0;
`endif
                end else if (!(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)))) ok = 0;
            end
            7'h13: begin
                uses = 3'b110; b.flags[7] = 1; im = s >>> 20;
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) ok = (f7 == 0 || f7 == 32);
            end
            7'h03: begin uses = 3'b110; b.flags[6] = 1; im = s >>> 20; ok = f3 inside {0, 1, 2, 4, 5}; end
            7'h23: begin
                uses = 3'b011; b.flags[5] = 1; ok = (f3 <= 2);
                im = ((s >>> 25) <<< 5) | int'(w[11:7]);
            end
            7'h63: begin
                uses = 3'b011; b.flags[4] = 1; ok = !(f3 inside {2, 3});
                im = ((s >>> 31) <<< 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1);
            end
            7'h37: begin uses = 3'b100; b.flags[2] = 1; im = s & 32'hFFFFF000; end
            7'h17: begin uses = 3'b100; b.flags[1] = 1; im = s & 32'hFFFFF000; end
            7'h6F: begin
                uses = 3'b100; b.flags[3] = 1;
                im = ((s >>> 31) <<< 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11) | (int'(w[30:21]) << 1);
            end
            7'h67: begin uses = 3'b110; b.flags[3] = 1; im = s >>> 20; ok = (f3 == 0); end
            default: ok = 0;
        endcase
        if (rv32e && ((uses[2] && w[11:7] >= 16) || (uses[1] && w[19:15] >= 16) || (uses[0] && w[24:20] >= 16)))
            ok = 0;
        b.pc     = pc;
        b.opcode = w[6:0];
        b.f3     = w[14:12];
        b.f7     = w[31:25];
        b.rd     = rv32e ? w[11:7] % 16 : w[11:7];
        b.rs1    = rv32e ? w[19:15] % 16 : w[19:15];
        b.rs2    = rv32e ? w[24:20] % 16 : w[24:20];
        b.imm    = im;
        if (!ok) begin
            b.flags   = '0;
            b.imm     = '0;
            b.illegal = 1;
        end
        return b;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_output(input string name, input bund_t act, input bund_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Recorder: an accepted push enqueues its expected bundle; flush or reset discards all.
    always @(negedge clk) begin
        #1;
        if (reset || flush) begin
            exp_i.delete();
            exp_e.delete();
        end else if (in_valid && i_in_ready) begin
            exp_i.push_back(ref_decode(in_instr, in_pc, 1'b0));
            exp_e.push_back(ref_decode(in_instr, in_pc, 1'b1));
        end
    end

    // Monitor: whenever a bundle is presented it must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (i_out_valid) begin
                if (exp_i.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL bundle_i unexpected actual=%h expected=none", act_i);
                end else begin
                    check_output("bundle_i", act_i, exp_i[0]);
                    if (out_ready) void'(exp_i.pop_front());
                end
            end
            if (e_out_valid) begin
                if (exp_e.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL bundle_e unexpected actual=%h expected=none", act_e);
                end else begin
                    check_output("bundle_e", act_e, exp_e[0]);
                    if (out_ready) void'(exp_e.pop_front());
                end
            end
        end
    end

    // Holds in_valid until the word is taken; returns just after the accepting edge.
    task automatic apply_stimulus(input logic [31:0] w, input logic [31:0] pc);
        int guard = 0;
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
        @(negedge clk);
        while (!i_in_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 50) begin
            checks++; errors++;
            $display("[TB] FAIL push_timeout actual=in_ready_low expected=accept");
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name);
        int guard = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_i.size() != 0 || exp_e.size() != 0) && guard < 200) begin
            guard++;
            @(posedge clk); #1;
        end
        check_val(name, exp_i.size() + exp_e.size(), 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  ops [9];
        int          k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        w = $urandom;
        k = $urandom_range(0, 11);
        if (k < 9) w[6:0] = ops[k];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'b0000000;
            1: w[31:25] = 7'b0100000;
            2: w[31:25] = 7'b0000001;
            default: ;
        endcase
        if ($urandom_range(0, 1) == 0) begin
            w[11] = 1'b0; w[19] = 1'b0; w[24] = 1'b0;
        end
        return w;
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_out_valid", i_out_valid, 0);
        check_val("reset_in_ready", i_in_ready, 1);
        check_val("reset_imm", i_imm, 0);
        check_val("reset_rd", i_rd, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_val("release_in_ready", i_in_ready, 1);

        $display("[TB] addi latency");
        @(posedge clk); #1;
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check_val("addi_not_yet", i_out_valid, 0);
        @(negedge clk);
        check_val("addi_valid", i_out_valid, 1);
        check_val("addi_rd", i_rd, 1);
        check_val("addi_rs1", i_rs1, 0);
        check_val("addi_imm", i_imm, 5);
        check_val("addi_alu", i_alu, 1);
        check_val("addi_illegal", i_illegal, 0);
        @(posedge clk); #1;

        $display("[TB] sw then lui back to back");
        apply_stimulus(32'h0020A423, 32'h104);
        apply_stimulus(32'h123452B7, 32'h108);
        wait_drain("drain_sw_lui");

        $display("[TB] stall with 5 pushes");
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) apply_stimulus(32'h00100093 + (n << 20), 32'h200 + n * 4);
        in_valid = 1'b0;
        @(negedge clk);
        check_val("full_in_ready", i_in_ready, 0);
        check_val("full_queued", exp_i.size(), 5);
        repeat (3) @(posedge clk);
        #1 wait_drain("drain_stall");

        $display("[TB] jal and zero word");
        apply_stimulus(32'hFFDFF0EF, 32'h300);
        apply_stimulus(32'h00000000, 32'h304);
        wait_drain("drain_jal");

        $display("[TB] mul");
        apply_stimulus(32'h022081B3, 32'h400);
        wait_drain("drain_mul");

        $display("[TB] flush on full queue");
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) apply_stimulus(32'h00000013 + (n << 7), 32'h500 + n * 4);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h600;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check_val("flush_out_valid", i_out_valid, 0);
        check_val("flush_in_ready", i_in_ready, 1);
        repeat (2) @(negedge clk);
        check_val("flush_dropped", i_out_valid, 0);

        $display("[TB] rv32e register range");
        @(posedge clk); #1;
        apply_stimulus(32'h00080813, 32'h700);
        wait_drain("drain_rv32e");

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = {$urandom, 2'b00};
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            reset     = (c == 300 || c == 301);
            @(posedge clk); #1;
        end
        flush = 1'b0; reset = 1'b0;
        wait_drain("drain_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
